// File: rtl/imem_loader_responder.sv
// Instruction-memory responder: byte-serial boot load after reset, then 1-cycle-latency fetch reads.
// Optional feature macro IMEM_RELOAD_EN adds a load_start input that re-enters the load phase from RUN.
module imem_loader_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] instruction_address,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              stall,
  input  logic [7:0]        load_byte,
  input  logic              load_byte_valid,
  output logic              load_byte_ready,
  input  logic              load_last,
`ifdef IMEM_RELOAD_EN
  input  logic              load_start,
`endif
  output logic              load_done,
  output logic              load_overflow
);

  localparam int                WPTR_W   = ADDR_W - 2;
  localparam logic [WPTR_W-1:0] LAST_PTR = WPTR_W'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WPTR_W-1:0] word_ptr_q, word_ptr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              mem_we_s;
  logic [31:0]       merged_s;
  logic [WPTR_W-1:0] rd_idx_s;
  logic              unused_addr_lsb_s;

  // Bytes land in order, so unfilled upper lanes of asm_q are always zero.
  assign merged_s          = asm_q | ({24'h000000, load_byte} << {byte_cnt_q, 3'b000});
  assign rd_idx_s          = instruction_address[ADDR_W-1:2];
  assign unused_addr_lsb_s = ^instruction_address[1:0];

  // Next-state, word assembly and read-data selection
  always_comb begin
    state_d       = state_q;
    word_ptr_d    = word_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    done_d        = done_q;
    ovf_d         = ovf_q;
    instr_d       = NOP_WORD;
    instr_valid_d = 1'b0;
    mem_we_s      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (load_byte_valid) begin
          if (load_last || (byte_cnt_q == 2'd3)) begin
            mem_we_s   = 1'b1;
            asm_d      = 32'h00000000;
            byte_cnt_d = 2'd0;
            if (load_last) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else if (word_ptr_q == LAST_PTR) begin
              // Image too large: stop without wrapping the write pointer.
              state_d = ST_RUN;
              done_d  = 1'b1;
              ovf_d   = 1'b1;
            end else begin
              word_ptr_d = word_ptr_q + {{(WPTR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            asm_d      = merged_s;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          asm_d = asm_q;
        end
      end
      ST_RUN: begin
`ifdef IMEM_RELOAD_EN
        if (load_start) begin
          state_d    = ST_LOAD;
          word_ptr_d = '0;
          byte_cnt_d = 2'd0;
          asm_d      = 32'h00000000;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
        end else begin
          instr_d       = mem_q[rd_idx_s];
          instr_valid_d = 1'b1;
        end
`else
        instr_d       = mem_q[rd_idx_s];
        instr_valid_d = 1'b1;
`endif
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      word_ptr_q    <= '0;
      byte_cnt_q    <= 2'd0;
      asm_q         <= 32'h00000000;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_ptr_q    <= word_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
    end
  end

  // Instruction storage survives reset so a reset never loses a loaded image
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_ptr_q] <= merged_s;
    end
  end

  assign instruction     = instr_q;
  assign instr_valid     = instr_valid_q;
  assign stall           = (state_q == ST_LOAD);
  assign load_byte_ready = (state_q == ST_LOAD);
  assign load_done       = done_q;
  assign load_overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader_responder.sv
// Self-checking bench for imem_loader_responder: spec-level model compared every cycle plus literal pins.
module tb_imem_loader_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = 10'h000;
  logic [31:0] instruction;
  logic        instr_valid, stall, lbr, done, ovf;
  logic [7:0]  lb = 8'h00;
  logic        lbv = 1'b0;
  logic        ll = 1'b0;
`ifdef IMEM_RELOAD_EN
  logic        ls = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  imem_loader_responder dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instruction_address(addr),
    .instruction        (instruction),
    .instr_valid        (instr_valid),
    .stall              (stall),
    .load_byte          (lb),
    .load_byte_valid    (lbv),
    .load_byte_ready    (lbr),
    .load_last          (ll),
`ifdef IMEM_RELOAD_EN
    .load_start         (ls),
`endif
    .load_done          (done),
    .load_overflow      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a boot image is a stream of bytes cut into little-endian words.
  logic [31:0] m_mem [256];
  logic [7:0]  m_bytes [$];
  logic [31:0] m_word;
  int          m_words = 0;
  bit          m_loading = 1'b1;
  bit          m_done = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b1; m_bytes.delete(); m_words = 0;
      m_done = 1'b0; m_ovf = 1'b0; m_valid = 1'b0; m_instr = NOP;
    end else if (m_loading) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (lbv) begin
        m_bytes.push_back(lb);
        if (ll || m_bytes.size() == 4) begin
          m_word = 32'h0;
          foreach (m_bytes[i]) m_word = m_word + (32'(m_bytes[i]) << (8 * i));
          m_mem[m_words] = m_word;
          m_words++;
          m_bytes.delete();
          if (ll) m_loading = 1'b0;
          else if (m_words == 256) begin
            m_loading = 1'b0;
            m_ovf = 1'b1;
          end
          m_done = !m_loading;
        end
      end
    end else begin
`ifdef IMEM_RELOAD_EN
      if (ls) begin
        m_loading = 1'b1; m_words = 0; m_bytes.delete();
        m_done = 1'b0; m_ovf = 1'b0; m_valid = 1'b0; m_instr = NOP;
      end else
`endif
      begin
        m_instr = m_mem[(int'(addr) / 4) % 256];
        m_valid = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(m_loading));
    chk("load_byte_ready", 32'(lbr), 32'(m_loading));
    chk("load_done", 32'(done), 32'(m_done));
    chk("load_overflow", 32'(ovf), 32'(m_ovf));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instruction", instruction, m_instr);
  end

  task automatic send(input logic [7:0] b, input logic last);
    lb = b; lbv = 1'b1; ll = last;
    @(posedge clk); #1;
    lbv = 1'b0; ll = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    addr = a;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd1);
    chk("reset_instruction", instruction, NOP);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Two-word image
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0);
    chk("t1_stall_before_last", 32'(stall), 32'd1);
    send(8'h00, 1'b1);
    chk("t1_stall_after_last", 32'(stall), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ovf", 32'(ovf), 32'd0);
    chk("t1_first_run_valid", 32'(instr_valid), 32'd0);
    rd(10'h000); chk("t1_mem0", instruction, 32'h00000013);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    rd(10'h004); chk("t1_mem1", instruction, 32'h00100093);
    rd(10'h006); chk("t1_mem1_lsb_ignored", instruction, 32'h00100093);

    // Partial word with gaps and a stray load_last without valid
    do_reset();
    ll = 1'b1; idle(1); ll = 1'b0;
    send(8'hAA, 1'b0); idle(3);
    send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    chk("t2_run", 32'(stall), 32'd0);
    rd(10'h000); chk("t2_mem0", instruction, 32'h00CCBBAA);
    rd(10'h004); chk("t2_mem1_retained", instruction, 32'h00100093);

    // Reset mid-word restarts assembly
    do_reset();
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    rst_n = 1'b0; #2;
    chk("t3_stall_in_reset", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    rd(10'h000); chk("t3_mem0", instruction, 32'h44332211);

    // Overflow: 1024 bytes, no load_last
    do_reset();
    for (int i = 0; i < 1024; i++) send(8'(i), 1'b0);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_stall", 32'(stall), 32'd0);
    send(8'hEE, 1'b0); send(8'hEE, 1'b0);
    chk("t4_not_ready", 32'(lbr), 32'd0);
    rd(10'h3FC); chk("t4_mem255", instruction, 32'hFFFEFDFC);
    rd(10'h004); chk("t4_mem1", instruction, 32'h07060504);
    rd(10'h000); chk("t4_mem0", instruction, 32'h03020100);

`ifdef IMEM_RELOAD_EN
    ls = 1'b1; @(posedge clk); #1; ls = 1'b0;
    chk("t5_stall", 32'(stall), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ovf", 32'(ovf), 32'd0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    rd(10'h000); chk("t5_mem0", instruction, 32'h04030201);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader_responder.md
Name: imem_loader_responder

Overview:
- Instruction-memory responder on the far end of the fetch interface.
- Receives the fetch stage's 10-bit byte `instruction_address` and returns the addressed 32-bit instruction word.
- After reset, owns a byte-serial boot-load port: incoming bytes are assembled into words and written into memory.
- Holds the fetch stage stalled until loading completes, then serves reads with fixed 1-cycle latency.

Parameters:
- ADDR_W, 10, byte-address width of `instruction_address`.
- DEPTH_WORDS, 256, number of 32-bit words; must equal 2**(ADDR_W-2).
- NOP_WORD, 32'h00000013, word driven on `instruction` while not serving valid reads (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruction_address  in  ADDR_W  byte address from fetch; bits [1:0] ignored.
- instruction  out  32  registered read data.
- instr_valid  out  1  `instruction` corresponds to the address presented in the previous cycle.
- stall  out  1  drives the fetch stage's stall input; high while loading.
- load_byte  in  8  boot-load data byte.
- load_byte_valid  in  1  `load_byte` is presented this cycle.
- load_byte_ready  out  1  byte accepted when valid&&ready.
- load_last  in  1  qualifies the final byte; sampled only with load_byte_valid&&load_byte_ready.
- load_done  out  1  sticky; high once in RUN.
- load_overflow  out  1  sticky; image exceeded DEPTH_WORDS.

Behaviour:
- Reset values: state=LOAD, word_ptr=0, byte_cnt=0, assembly reg=0, instruction=NOP_WORD, instr_valid=0, stall=1, load_byte_ready=1, load_done=0, load_overflow=0.
- Memory array is not cleared by reset.
- Async reset mid-load or mid-run returns immediately to the reset values; previously written words are retained.
- LOAD state:
  - stall=1, load_byte_ready=1, instr_valid=0, instruction=NOP_WORD.
  - Bytes are little-endian: byte_cnt 0..3 selects bits [7:0],[15:8],[23:16],[31:24].
  - On accepting the byte with byte_cnt==3: write the assembled word to mem[word_ptr], word_ptr+1, byte_cnt=0.
  - On accepting a byte with load_last=1 at any byte_cnt: fill unfilled upper bytes with 0, write mem[word_ptr], go to RUN next cycle.
  - Writing mem[DEPTH_WORDS-1] without load_last: set load_overflow=1, go to RUN; word_ptr does not wrap and no further writes occur.
  - load_last while load_byte_valid=0: ignored.
  - Cycles without valid: no state change; the partial word is held indefinitely.
- RUN state:
  - stall=0, load_byte_ready=0, load_done=1; load bytes are ignored.
  - Each cycle registers instruction <= mem[instruction_address[ADDR_W-1:2]], so latency is exactly 1 cycle.
  - instr_valid=0 in the first RUN cycle and 1 from the second RUN cycle onward.
  - Same-cycle write/read cannot occur (writes happen only in LOAD).
- Transition cycle: the cycle that writes the final word still drives stall=1; stall falls on the next edge.
- Address wrap: word index is truncated to ADDR_W-2 bits; addresses beyond the array alias modulo DEPTH_WORDS.

Optional Feature:
- Macro IMEM_RELOAD_EN.
- When defined:
  - Adds input `load_start` (1 bit).
  - `load_start` high in RUN for one cycle returns to LOAD next cycle: word_ptr=0, byte_cnt=0, load_done=0, load_overflow=0, stall=1, instr_valid=0.
  - `load_start` in LOAD is ignored.
- When undefined:
  - No `load_start` port.
  - RUN is left only via rst_n.

Test Plan:
- Reset, send bytes 13,00,00,00,93,00,10,00 with load_last on the 8th → mem[0]=32'h00000013, mem[1]=32'h00100093, stall falls one cycle after the last byte, load_done=1, load_overflow=0.
- Send 3 bytes AA,BB,CC with load_last on CC → mem[0]=32'h00CCBBAA, RUN entered.
- In RUN, present address 0x004 then 0x006 → instruction=32'h00100093 one cycle after each (bits [1:0] ignored), instr_valid=1.
- Send 1024 bytes without load_last → load_overflow=1 after the 256th word write, RUN entered, further bytes not accepted (load_byte_ready=0).
- Assert rst_n low mid-word (after 2 bytes), release, load a 1-word image → byte_cnt restarted, mem[0] holds the new word, stall=1 throughout loading.
- With IMEM_RELOAD_EN: in RUN pulse load_start → stall=1 and load_done=0 next cycle; reload 4 bytes 01,02,03,04 with last → mem[0]=32'h04030201.
